// File: rtl/ifq_fetch_unit.sv
// ---------------------------------------------------------------------------
// ifq_fetch_unit -- instruction fetch queue feeding the dispatch unit.
//
// Keeps the fetch PC and issues sequential instruction-memory reads, at most
// one in flight. Returned words are stored with their PC in a
// first-word-fall-through FIFO whose head is presented to dispatch. A
// dispatch redirect flushes the FIFO, marks any in-flight read as stale and
// restarts fetch at the redirect target.
//
// Build option:
//   IFQ_BYPASS_EN  When defined, a non-stale response that arrives while the
//                  FIFO is empty is shown on the ifq_* outputs in its arrival
//                  cycle, and is not stored if dispatch consumes it then.
//                  When undefined, ifq_* outputs come only from FIFO storage.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset
//
// Ports:
//   clk               clock
//   rst               synchronous active-high reset
//   dpch_rd           dispatch pops the head entry (ignored when empty)
//   dpch_jmp          redirect request from dispatch
//   dpch_jmp_br_addr  redirect target
//   ifq_pc            PC of head entry
//   ifq_icode         instruction word of head entry
//   ifq_empty         1 = no valid head entry
//   icache_rd_en      read request, accepted in the cycle it is high
//   icache_addr       word address of the request (fetch PC)
//   icache_data       returned instruction word
//   icache_valid      return strobe, in order, >= 1 cycle after the request
// ---------------------------------------------------------------------------

// Simulation-only checker: the issue rule must make FIFO overflow impossible.
module ifq_fetch_unit_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          i_push,
  input logic          i_pop,
  input logic [CW-1:0] i_count
);

  // A push without a matching pop into a full FIFO would overwrite the head.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_pop && (i_count == CW'(DEPTH))));

endmodule

module ifq_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dpch_rd,
  input  logic        dpch_jmp,
  input  logic [31:0] dpch_jmp_br_addr,
  output logic [31:0] ifq_pc,
  output logic [31:0] ifq_icode,
  output logic        ifq_empty,
  output logic        icache_rd_en,
  output logic [31:0] icache_addr,
  input  logic [31:0] icache_data,
  input  logic        icache_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic          r_outstanding;
  logic          r_stale;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_icode [DEPTH];

  logic [CW:0]   w_occupancy;
  logic          w_issue;
  logic          w_resp;
  logic          w_resp_keep;
  logic          w_push;
  logic          w_pop;
  logic          w_count_zero;

  assign w_count_zero = (r_count == {CW{1'b0}});

  // Entries held plus the one in flight must leave room for the next word.
  assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_outstanding};
  assign w_issue     = !rst && !r_outstanding && !dpch_jmp &&
                       (w_occupancy < (CW+1)'(DEPTH));

  assign w_resp      = icache_valid && r_outstanding;
  // A response is dropped if it belongs to a pre-redirect fetch or arrives
  // in the redirect cycle itself.
  assign w_resp_keep = w_resp && !r_stale && !dpch_jmp;
  assign w_pop       = dpch_rd && !dpch_jmp && !w_count_zero;

`ifdef IFQ_BYPASS_EN
  logic w_bypass;
  logic w_consume;

  assign w_bypass  = w_resp_keep && w_count_zero;
  // Word taken by dispatch straight off the bus never enters the FIFO.
  assign w_consume = w_bypass && dpch_rd;
  assign w_push    = w_resp_keep && !w_consume;

  // Head comes from the bus when bypassing, otherwise from FIFO storage.
  always_comb begin
    if (w_bypass) begin
      ifq_pc    = r_req_pc;
      ifq_icode = icache_data;
      ifq_empty = 1'b0;
    end else begin
      ifq_pc    = r_mem_pc[r_rd_ptr];
      ifq_icode = r_mem_icode[r_rd_ptr];
      ifq_empty = w_count_zero;
    end
  end
`else
  assign w_push = w_resp_keep;

  // Head comes only from FIFO storage; while empty, rd_ptr's slot is not
  // written until a push, so the outputs hold steady.
  always_comb begin
    ifq_pc    = r_mem_pc[r_rd_ptr];
    ifq_icode = r_mem_icode[r_rd_ptr];
    ifq_empty = w_count_zero;
  end
`endif

  assign icache_rd_en = w_issue;
  assign icache_addr  = r_fetch_pc;

  // Fetch PC, in-flight tracking and stale marking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= 32'h0000_0000;
      r_outstanding <= 1'b0;
      r_stale       <= 1'b0;
    end else begin
      if (w_issue) begin
        r_outstanding <= 1'b1;
        r_req_pc      <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
      end else if (w_resp) begin
        r_outstanding <= 1'b0;
      end

      if (dpch_jmp) begin
        r_fetch_pc <= dpch_jmp_br_addr;
        // Only a read still waiting past this cycle needs to be dropped later.
        r_stale    <= r_outstanding && !icache_valid;
      end else if (w_resp) begin
        r_stale <= 1'b0;
      end
    end
  end

  // FIFO storage, pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= {CW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= 32'h0000_0000;
        r_mem_icode[i] <= 32'h0000_0000;
      end
    end else if (dpch_jmp) begin
      r_count  <= {CW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem_pc[r_wr_ptr]    <= r_req_pc;
        r_mem_icode[r_wr_ptr] <= icache_data;
        r_wr_ptr              <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  ifq_fetch_unit_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_count (r_count)
  );

endmodule

// File: tb/tb_ifq_fetch_unit.sv
// ---------------------------------------------------------------------------
// Directed testbench for ifq_fetch_unit. A small in-order memory model with a
// configurable latency answers each request with its address as data (or a
// fixed word when selected). Every observation is taken 1 time unit after the
// falling edge, once the cycle's inputs have settled.
// ---------------------------------------------------------------------------
module tb_ifq_fetch_unit;

  logic        clk;
  logic        rst;
  logic        dpch_rd;
  logic        dpch_jmp;
  logic [31:0] dpch_jmp_br_addr;
  logic [31:0] ifq_pc;
  logic [31:0] ifq_icode;
  logic        ifq_empty;
  logic        icache_rd_en;
  logic [31:0] icache_addr;
  logic [31:0] icache_data;
  logic        icache_valid;

  ifq_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0040_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .dpch_rd          (dpch_rd),
    .dpch_jmp         (dpch_jmp),
    .dpch_jmp_br_addr (dpch_jmp_br_addr),
    .ifq_pc           (ifq_pc),
    .ifq_icode        (ifq_icode),
    .ifq_empty        (ifq_empty),
    .icache_rd_en     (icache_rd_en),
    .icache_addr      (icache_addr),
    .icache_data      (icache_data),
    .icache_valid     (icache_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;

  // memory model state
  int          cyc;
  int          lat;
  bit          mem_pend;
  int          mem_due;
  logic [31:0] mem_addr;
  bit          force_valid;
  logic [31:0] force_data;
  bit          mem_fixed_en;
  logic [31:0] mem_fixed;

  // values observed in the most recent cycle
  logic        s_rd_en;
  logic        s_empty;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_icode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // One clock cycle: drive memory response, observe, clock, update memory.
  task automatic tick();
    if (rst)
      icache_valid = 1'b0;
    else
      icache_valid = force_valid || (mem_pend && (mem_due == cyc));
    if (force_valid)       icache_data = force_data;
    else if (mem_fixed_en) icache_data = mem_fixed;
    else                   icache_data = mem_addr;
    #1;
    s_rd_en = icache_rd_en;
    s_addr  = icache_addr;
    s_empty = ifq_empty;
    s_pc    = ifq_pc;
    s_icode = ifq_icode;
    @(posedge clk);
    if (rst) begin
      mem_pend = 1'b0;
    end else begin
      if (icache_valid && !force_valid) mem_pend = 1'b0;
      if (s_rd_en) begin
        mem_pend = 1'b1;
        mem_due  = cyc + lat;
        mem_addr = s_addr;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    dpch_rd     = 1'b0;
    dpch_jmp    = 1'b0;
    force_valid = 1'b0;
    tick();
    tick();
    rst      = 1'b0;
    cyc      = 0;
    mem_pend = 1'b0;
  endtask

  initial begin
    logic [31:0] iss_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] ic_q[$];
    logic [31:0] last_iss;
    logic [31:0] first_head;
    int          n_iss;
    int          first_k;
    bit          head_seen;
    int          exp_pops;

    rst = 1'b1; dpch_rd = 1'b0; dpch_jmp = 1'b0; dpch_jmp_br_addr = 32'h0;
    icache_valid = 1'b0; icache_data = 32'h0;
    force_valid = 1'b0; force_data = 32'h0; mem_fixed_en = 1'b0; mem_fixed = 32'h0;
    cyc = 0; lat = 1; mem_pend = 1'b0; mem_due = 0; mem_addr = 32'h0;
    @(negedge clk);

    // ---- 1: reset state, then free-run until the FIFO is full ----
    tick();
    check("rst_rd_en_low", 32'(s_rd_en), 32'd0);
    do_reset();
    lat = 1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (c == 0) begin
        check("post_rst_empty", 32'(s_empty), 32'd1);
        check("post_rst_pc",    s_pc,         32'h0000_0000);
        check("post_rst_icode", s_icode,      32'h0000_0000);
        check("post_rst_addr",  s_addr,       32'h0040_0000);
        check("post_rst_rd_en", 32'(s_rd_en), 32'd1);
      end
      if (s_rd_en) iss_q.push_back(s_addr);
    end
    check("fill_issue_cnt", 32'(iss_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < iss_q.size(); i++)
      check("fill_issue_addr", iss_q[i], 32'h0040_0000 + 32'(4 * i));
    check("full_rd_en",  32'(s_rd_en), 32'd0);
    check("full_empty",  32'(s_empty), 32'd0);
    check("full_head_pc", s_pc,        32'h0040_0000);
    check("full_head_ic", s_icode,     32'h0040_0000);

    // ---- 2: continuous dispatch, 1-cycle memory ----
    do_reset();
    dpch_rd = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
`ifdef IFQ_BYPASS_EN
      check("stream_empty", 32'(s_empty), (c % 2 == 0) ? 32'd1 : 32'd0);
`else
      check("stream_empty", 32'(s_empty), (c >= 2 && c % 2 == 0) ? 32'd0 : 32'd1);
`endif
      if (!s_empty) begin
        pc_q.push_back(s_pc);
        ic_q.push_back(s_icode);
      end
    end
`ifdef IFQ_BYPASS_EN
    exp_pops = 6;
`else
    exp_pops = 5;
`endif
    check("stream_pops", 32'(pc_q.size()), 32'(exp_pops));
    for (int i = 0; i < pc_q.size(); i++) begin
      check("stream_pc", pc_q[i], 32'h0040_0000 + 32'(4 * i));
      check("stream_ic", ic_q[i], 32'h0040_0000 + 32'(4 * i));
    end
    dpch_rd = 1'b0;

    // ---- 3: redirect with a read outstanding on a 3-cycle memory ----
    do_reset();
    lat = 3;
    dpch_rd = 1'b1;
    n_iss = 0;
    last_iss = 32'h0;
    for (int c = 0; c < 17; c++) begin
      tick();
      if (s_rd_en) begin
        n_iss++;
        last_iss = s_addr;
      end
    end
    check("pre_jmp_issues", 32'(n_iss), 32'd5);
    check("pre_jmp_last",   last_iss,   32'h0040_0010);
    dpch_jmp = 1'b1;
    dpch_jmp_br_addr = 32'h0040_0100;
    tick();
    check("jmp_cycle_rd_en", 32'(s_rd_en), 32'd0);
    dpch_jmp = 1'b0;
    dpch_rd  = 1'b0;
    first_k = -1;
    last_iss = 32'hFFFF_FFFF;
    head_seen = 1'b0;
    first_head = 32'hFFFF_FFFF;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (s_rd_en && first_k < 0) begin
        first_k  = k;
        last_iss = s_addr;
      end
      if (!s_empty && !head_seen) begin
        head_seen  = 1'b1;
        first_head = s_pc;
      end
      if (first_k >= 0 && head_seen) break;
    end
    check("stale_reissue_delay", 32'(first_k), 32'd2);
    check("stale_reissue_addr",  last_iss,     32'h0040_0100);
    check("stale_first_head",    first_head,   32'h0040_0100);

    // ---- 4: redirect coinciding with a response, count=2, dpch_rd=1 ----
    do_reset();
    lat = 1;
    for (int c = 0; c < 5; c++) tick();
    dpch_jmp = 1'b1;
    dpch_jmp_br_addr = 32'h0040_0200;
    dpch_rd = 1'b1;
    tick();
    check("jv_pre_empty", 32'(s_empty), 32'd0);
    check("jv_pre_pc",    s_pc,         32'h0040_0000);
    dpch_jmp = 1'b0;
    dpch_rd  = 1'b0;
    tick();
    check("jv_flush_empty", 32'(s_empty), 32'd1);
    check("jv_rd_en",       32'(s_rd_en), 32'd1);
    check("jv_addr",        s_addr,       32'h0040_0200);
    tick();
    tick();
    check("jv_head_empty", 32'(s_empty), 32'd0);
    check("jv_head_pc",    s_pc,         32'h0040_0200);
    check("jv_head_ic",    s_icode,      32'h0040_0200);

    // ---- 5: reset mid-stream with 3 entries and a read outstanding ----
    do_reset();
    lat = 1;
    for (int c = 0; c < 7; c++) tick();
    check("mid_pre_issue", s_addr, 32'h0040_000C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force_valid = 1'b1;
    force_data  = 32'hDEAD_BEEF;
    tick();
    check("mid_rst_empty", 32'(s_empty), 32'd1);
    check("mid_rst_addr",  s_addr,       32'h0040_0000);
    check("mid_rst_rd_en", 32'(s_rd_en), 32'd1);
    force_valid = 1'b0;
    tick();
    tick();
    check("mid_head_empty", 32'(s_empty), 32'd0);
    check("mid_head_pc",    s_pc,         32'h0040_0000);
    check("mid_head_ic",    s_icode,      32'h0040_0000);

    // ---- 6: response into an empty FIFO with dpch_rd=1 ----
    do_reset();
    lat = 1;
    mem_fixed_en = 1'b1;
    mem_fixed    = 32'h0000_0013;
    tick();
    dpch_rd = 1'b1;
    tick();
`ifdef IFQ_BYPASS_EN
    check("byp_arrive_empty", 32'(s_empty), 32'd0);
    check("byp_arrive_ic",    s_icode,      32'h0000_0013);
    check("byp_arrive_pc",    s_pc,         32'h0040_0000);
    dpch_rd = 1'b0;
    tick();
    check("byp_after_empty",  32'(s_empty), 32'd1);
`else
    check("nobyp_arrive_empty", 32'(s_empty), 32'd1);
    dpch_rd = 1'b0;
    tick();
    check("nobyp_after_empty", 32'(s_empty), 32'd0);
    check("nobyp_after_ic",    s_icode,      32'h0000_0013);
    check("nobyp_after_pc",    s_pc,         32'h0040_0000);
`endif
    mem_fixed_en = 1'b0;

    // ---- 7: fetch PC wraps past 0xFFFFFFFC ----
    do_reset();
    lat = 1;
    dpch_jmp = 1'b1;
    dpch_jmp_br_addr = 32'hFFFF_FFFC;
    tick();
    check("wrap_jmp_rd_en", 32'(s_rd_en), 32'd0);
    dpch_jmp = 1'b0;
    tick();
    check("wrap_first_rd_en", 32'(s_rd_en), 32'd1);
    check("wrap_first_addr",  s_addr,       32'hFFFF_FFFC);
    tick();
    tick();
    check("wrap_next_rd_en", 32'(s_rd_en), 32'd1);
    check("wrap_next_addr",  s_addr,       32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
